barrel_shifter_op: RTL and testbench
====================================

Name: barrel_shifter_op

Overview:
- Parameterised rotating barrel shifter with a registered output.
- Rotates an input word left or right by 0..WIDTH-1 positions in a single pass through a log2(WIDTH)-stage mux network.
- Captures the result in an output register.
- Used as a datapath primitive, for example in ALU shift paths, wherever a one-cycle-latency rotate is needed.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- SHW, $clog2(WIDTH) (3 at default), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in1  input  WIDTH  data word to rotate.
- shift  input  SHW  rotate amount, 0..WIDTH-1.
- LR  input  1  direction: 0 = rotate left (toward MSB), 1 = rotate right (toward LSB).
- in_valid  input  1  qualifies in1/shift/LR for capture this cycle.
- data_out  output  WIDTH  registered rotate result.
- out_valid  output  1  high the cycle after an accepted input.

Behaviour:
- Reset is synchronous and active-high. On a rising clk edge with rst=1:
  - data_out <= 0.
  - out_valid <= 0.
  - rst takes priority over in_valid in that cycle.
- Rotation, not shift: every bit that exits one end re-enters at the other; no bits are lost or zero-filled.
  - Left: data_out[i] = in1[(i - shift) mod WIDTH].
  - Right: data_out[i] = in1[(i + shift) mod WIDTH].
- shift = 0 passes in1 unchanged in either direction.
- A left rotate by k equals a right rotate by WIDTH-k; the bench checks this equivalence.
- Datapath structure:
  - Stage s (s = 0..SHW-1) rotates by 2^s when shift[s]=1, otherwise passes its input through.
  - Stages are purely combinational; direction is applied uniformly in every stage.
  - No register between stages.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on data_out after edge N.
- Accept: in_valid=1 at an edge with rst=0 updates data_out and sets out_valid=1.
- Hold: in_valid=0 at an edge keeps data_out unchanged and clears out_valid to 0.
- Back-to-back accepts, one per cycle, are supported. There is no backpressure and no stall input.
- Inputs may change every cycle; only values present at the edge matter.
- After rst is released: data_out stays 0 and out_valid stays 0 until the first accepted input.
- X-free: all outputs are defined from the first post-reset edge.

Decomposition:
- Shared package barrel_pkg holds:
  - the direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1;
  - a function rot_ref(data, amt, dir), used only by the bench as a golden model.
- One sub-module, barrel_rot_stage: combinational, parameterised by WIDTH and STEP.
  - Ports: data in, en, dir, data out.
  - Instantiated SHW times via generate, with STEP = 1, 2, 4, ...
- The top level contains the stage chain plus the output register and the valid flop.

Test Plan:
- Reset: assert rst with in_valid=1, in1=8'hFF -> data_out=8'h00 and out_valid=0 on the next edge; holds while rst=1.
- Left sweep: in1=8'b00110011, LR=0, shift stepped 0..7 with in_valid=1.
  - Expected one cycle later: shift 0 -> 33, 1 -> 66, 2 -> CC, 3 -> 99, 4 -> 33, 5 -> 66, 6 -> CC, 7 -> 99 (hex).
- Right sweep: in1=8'h33, LR=1, shift 0..7.
  - Expected: shift 0 -> 33, 1 -> 99, 2 -> CC, 3 -> 66, 4 -> 33, 5 -> 99, 6 -> CC, 7 -> 66.
- Wrap-around:
  - in1=8'h81, LR=0, shift=1 -> 8'h03.
  - in1=8'h81, LR=1, shift=1 -> 8'hC0.
  - in1=8'h01, LR=1, shift=7 -> 8'h02.
- Hold/valid:
  - Accept 8'hA5 (shift 0), then drive in_valid=0 with in1=8'h00 for 3 cycles -> data_out stays A5 and out_valid reads 1 then 0,0,0.
  - Back-to-back accepts give out_valid=1 every cycle.
- Random plus equivalence: 1000 random (in1, shift, LR) vectors compared against rot_ref with 1-cycle alignment. Also check left-by-k equals right-by-(8-k) for all k.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared definitions for the rotating barrel shifter: direction encoding and
// a bit-by-bit rotate reference used as a golden model outside the datapath.
package barrel_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Rotates the low 'width' bits of data; bits above width are returned as zero.
  function automatic logic [63:0] rot_ref(input logic [63:0]  data,
                                          input int unsigned  amt,
                                          input logic         dir,
                                          input int unsigned  width = 8);
    logic [63:0] res;
    int unsigned k;
    int unsigned src;
    res = 64'd0;
    k   = amt % width;
    for (int unsigned i = 0; i < width; i++) begin
      if (dir == DIR_LEFT) begin
        src = (i + width - k) % width;
      end else begin
        src = (i + k) % width;
      end
      res[6'(i)] = data[6'(src)];
    end
    return res;
  endfunction

endpackage

// File: rtl/barrel_rot_stage.sv
// One combinational stage of the rotator: rotates by a fixed STEP in the
// requested direction when enabled, otherwise passes the word through.
module barrel_rot_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] rot_left_s;
  logic [WIDTH-1:0] rot_right_s;

  assign rot_left_s  = {data_in[WIDTH-STEP-1:0], data_in[WIDTH-1:WIDTH-STEP]};
  assign rot_right_s = {data_in[STEP-1:0], data_in[WIDTH-1:STEP]};

  // Select rotated or pass-through word for this stage
  always_comb begin
    data_out = data_in;
    case ({en, dir})
      {1'b1, DIR_LEFT}:  data_out = rot_left_s;
      {1'b1, DIR_RIGHT}: data_out = rot_right_s;
      default:           data_out = data_in;
    endcase
  end

endmodule

// File: rtl/barrel_shifter_op.sv
// Rotating barrel shifter: log2(WIDTH) power-of-two stages feeding a single
// output register, giving a one-cycle-latency rotate with a valid flag.
module barrel_shifter_op
  import barrel_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [SHW-1:0]   shift,
  input  logic             LR,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid
);

  logic [WIDTH-1:0] stage_data_s [SHW+1];
  logic [WIDTH-1:0] data_out_d;
  logic [WIDTH-1:0] data_out_q;
  logic             out_valid_d;
  logic             out_valid_q;

  assign stage_data_s[0] = in1;

  // Stage s contributes a rotate by 2^s when shift[s] is set
  for (genvar s = 0; s < SHW; s++) begin : g_stage
    barrel_rot_stage #(
      .WIDTH (WIDTH),
      .STEP  (32'd1 << s)
    ) u_stage (
      .data_in  (stage_data_s[s]),
      .en       (shift[s]),
      .dir      (LR),
      .data_out (stage_data_s[s+1])
    );
  end

  // Capture a new result on accept, otherwise hold data and drop valid
  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      data_out_d  = stage_data_s[SHW];
      out_valid_d = 1'b1;
    end else begin
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
    end
  end

  // Output and valid registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q  <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_barrel_shifter_op.sv
// Self-checking bench for barrel_shifter_op: directed sweeps, wrap-around,
// hold/valid, left/right equivalence and randomized vectors.
module tb_barrel_shifter_op;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [2:0] shift;
  logic       LR;
  logic       in_valid;
  logic [7:0] data_out;
  logic       out_valid;

  int errors;
  int checks;

  barrel_shifter_op #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .shift     (shift),
    .LR        (LR),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rotate via a doubled word: the wanted window slides across {d,d}
  function automatic logic [7:0] model_rot(input logic [7:0] d, input int k, input logic lr);
    logic [15:0] dbl;
    int          kk;
    kk  = k % 8;
    dbl = {d, d};
    if (lr == 1'b0) begin
      dbl = dbl << kk;
      return dbl[15:8];
    end else begin
      dbl = dbl >> kk;
      return dbl[7:0];
    end
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] d, input logic [2:0] s,
                       input logic lr, input logic v);
    @(negedge clk);
    rst      = r;
    in1      = d;
    shift    = s;
    LR       = lr;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] left_exp  [8];
  logic [7:0] right_exp [8];
  logic [7:0] exp_data;
  logic       exp_valid;
  logic [7:0] rd;
  logic [2:0] rs;
  logic       rlr;
  logic       rv;
  logic [63:0] ref_word;
  logic [7:0]  ref_byte;

  initial begin
    errors    = 0;
    checks    = 0;
    left_exp  = '{8'h33, 8'h66, 8'hCC, 8'h99, 8'h33, 8'h66, 8'hCC, 8'h99};
    right_exp = '{8'h33, 8'h99, 8'hCC, 8'h66, 8'h33, 8'h99, 8'hCC, 8'h66};
    rst = 1'b1; in1 = 8'hFF; shift = 3'd0; LR = 1'b0; in_valid = 1'b1;

    // Reset dominates a valid input and holds while asserted
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 8'hFF, 3'd2, 1'b0, 1'b1);
      check8("reset_data", data_out, 8'h00);
      check1("reset_valid", out_valid, 1'b0);
    end

    // Released with nothing accepted: stays cleared
    apply(1'b0, 8'hFF, 3'd1, 1'b0, 1'b0);
    check8("post_reset_data", data_out, 8'h00);
    check1("post_reset_valid", out_valid, 1'b0);

    // Back-to-back left sweep
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 8'b0011_0011, 3'(k), 1'b0, 1'b1);
      check8($sformatf("left_sweep_%0d", k), data_out, left_exp[k]);
      check1($sformatf("left_valid_%0d", k), out_valid, 1'b1);
    end

    // Back-to-back right sweep
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 8'h33, 3'(k), 1'b1, 1'b1);
      check8($sformatf("right_sweep_%0d", k), data_out, right_exp[k]);
      check1($sformatf("right_valid_%0d", k), out_valid, 1'b1);
    end

    // Wrap-around across the word ends
    apply(1'b0, 8'h81, 3'd1, 1'b0, 1'b1);
    check8("wrap_left_81", data_out, 8'h03);
    apply(1'b0, 8'h81, 3'd1, 1'b1, 1'b1);
    check8("wrap_right_81", data_out, 8'hC0);
    apply(1'b0, 8'h01, 3'd7, 1'b1, 1'b1);
    check8("wrap_right_01", data_out, 8'h02);

    // Hold: data sticks, valid drops after one cycle
    apply(1'b0, 8'hA5, 3'd0, 1'b1, 1'b1);
    check8("hold_accept", data_out, 8'hA5);
    check1("hold_accept_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 8'h00, 3'(i + 1), 1'b0, 1'b0);
      check8($sformatf("hold_data_%0d", i), data_out, 8'hA5);
      check1($sformatf("hold_valid_%0d", i), out_valid, 1'b0);
    end

    // Mid-run reset with a valid input present
    apply(1'b1, 8'h5A, 3'd3, 1'b0, 1'b1);
    check8("midreset_data", data_out, 8'h00);
    check1("midreset_valid", out_valid, 1'b0);

    // Left by k must equal right by 8-k
    for (int k = 0; k < 8; k++) begin
      rd = 8'($urandom);
      apply(1'b0, rd, 3'(k), 1'b0, 1'b1);
      check8($sformatf("equiv_left_%0d", k), data_out, model_rot(rd, k, 1'b0));
      apply(1'b0, rd, 3'((8 - k) % 8), 1'b1, 1'b1);
      check8($sformatf("equiv_right_%0d", k), data_out, model_rot(rd, k, 1'b0));
    end

    // Random vectors with occasional idle cycles
    exp_data  = data_out;
    exp_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rd  = 8'($urandom);
      rs  = 3'($urandom_range(7, 0));
      rlr = 1'($urandom);
      rv  = ($urandom_range(9, 0) != 0);
      ref_word = barrel_pkg::rot_ref(64'(rd), int'(rs), rlr, 8);
      ref_byte = ref_word[7:0];
      check8("rot_ref_vs_model", ref_byte, model_rot(rd, int'(rs), rlr));
      apply(1'b0, rd, rs, rlr, rv);
      if (rv) begin
        exp_data  = model_rot(rd, int'(rs), rlr);
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      check8("rand_data", data_out, exp_data);
      check1("rand_valid", out_valid, exp_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
